calc_sequencer: RTL and testbench

//  Program sequencer for the 8-bit signed stack calculator datapath. Fetches 11-bit instructions from the

---
 rtl/calc_pkg.sv | 32 +++
 rtl/calc_step_sync.sv | 31 +++
 rtl/calc_sequencer.sv | 159 +++++++++++++++
 tb/tb_calc_sequencer.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// Opcodes, trap codes and sequencer state encoding shared by the stack-calculator control blocks.
package calc_pkg;

    localparam logic [2:0] OP_ADD  = 3'b100;
    localparam logic [2:0] OP_SUB  = 3'b101;
    localparam logic [2:0] OP_MUL  = 3'b010;
    localparam logic [2:0] OP_PUSH = 3'b011;
    localparam logic [2:0] OP_HALT = 3'b111;

    typedef enum logic [1:0] {
        FC_NONE  = 2'b00,
        FC_FULL  = 2'b01,
        FC_UNDER = 2'b10,
        FC_OVF   = 2'b11
    } fault_code_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT,
        S_ISSUE,
        S_EXEC,
        S_NEXT,
        S_HALT,
        S_FAULT
    } state_t;

    function automatic logic is_binop(input logic [2:0] op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_MUL);
    endfunction

endpackage

// File: rtl/calc_step_sync.sv
// Brings raw run/step key levels into the clock domain (2-FF) and turns step into a one-cycle pulse.
// Latency: two cycles for run, two cycles for the step pulse; no backpressure.
module calc_step_sync (
    input  logic CLOCK_50,
    input  logic reset_n,
    input  logic run_key,
    input  logic step_key,
    output logic run_lvl,
    output logic step_pls
);

    logic [1:0] run_sync;
    logic [1:0] step_sync;
    logic       step_prev;

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            run_sync  <= 2'b00;
            step_sync <= 2'b00;
            step_prev <= 1'b0;
        end else begin
            run_sync  <= {run_sync[0], run_key};
            step_sync <= {step_sync[0], step_key};
            step_prev <= step_sync[1];
        end
    end

    assign run_lvl  = run_sync[1];
    assign step_pls = step_sync[1] & ~step_prev;

endmodule

// File: rtl/calc_sequencer.sv
// Program sequencer: fetches from the synchronous ROM, decodes, and issues one op at a time to the stack ALU.
// One instruction in flight; the issued op is held stable while alu_ready is low, HALT/FAULT are absorbing.
module calc_sequencer
    import calc_pkg::*;
#(
    parameter int AW      = 4,
    parameter int DEPTH   = 10,
    parameter int ROM_LAT = 1
) (
    input  logic          CLOCK_50,
    input  logic          reset_n,
    input  logic          run,
    input  logic          step,
    output logic [AW-1:0] rom_addr,
    input  logic [10:0]   rom_q,
    output logic          alu_valid,
    output logic [2:0]    alu_op,
    output logic [7:0]    alu_operand,
    input  logic          alu_ready,
    input  logic          alu_done,
    input  logic          alu_ovf,
    output logic [AW-1:0] pc,
    output logic [3:0]    depth,
    output logic          busy,
    output logic          halted,
    output logic          fault,
    output logic [1:0]    fault_code
);

    localparam logic [3:0] DEPTH_MAX = 4'(DEPTH);
    localparam logic [1:0] WAIT_INIT = 2'(ROM_LAT - 1);

    logic       run_lvl;
    logic       step_pls;
    state_t     state;
    state_t     state_nxt;
    logic [1:0] wait_cnt;
    logic       accepted;
    logic [2:0] ir_op;
    logic [7:0] ir_arg;
    logic       trap_full;
    logic       trap_under;
    logic       handshake;
    logic       op_done;

    calc_step_sync u_step_sync (
        .CLOCK_50 (CLOCK_50),
        .reset_n  (reset_n),
        .run_key  (run),
        .step_key (step),
        .run_lvl  (run_lvl),
        .step_pls (step_pls)
    );

    assign rom_addr   = pc;
    assign ir_op      = rom_q[10:8];
    assign ir_arg     = rom_q[7:0];
    assign trap_full  = (ir_op == OP_PUSH) && (depth == DEPTH_MAX);
    assign trap_under = is_binop(ir_op) && (depth < 4'd2);
    assign handshake  = alu_valid & alu_ready;
    // Completion may coincide with the accept cycle itself.
    assign op_done    = alu_done & (accepted | handshake);

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        case (state)
            S_IDLE:  if (run_lvl || step_pls) state_nxt = S_FETCH;
            S_FETCH: begin
                busy      = 1'b1;
                state_nxt = S_WAIT;
            end
            S_WAIT: begin
                busy = 1'b1;
                if (wait_cnt == 2'd0) state_nxt = S_ISSUE;
            end
            S_ISSUE: begin
                busy = 1'b1;
                if (ir_op == OP_HALT)
                    state_nxt = S_HALT;
                else if (ir_op == OP_PUSH || is_binop(ir_op))
                    state_nxt = (trap_full || trap_under) ? S_FAULT : S_EXEC;
                else
                    state_nxt = S_NEXT;
            end
            S_EXEC: begin
                busy = 1'b1;
                if (op_done) state_nxt = alu_ovf ? S_FAULT : S_NEXT;
            end
            S_NEXT:  state_nxt = run_lvl ? S_FETCH : S_IDLE;
            S_HALT:  state_nxt = S_HALT;
            S_FAULT: state_nxt = S_FAULT;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            pc          <= '0;
            depth       <= 4'd0;
            alu_valid   <= 1'b0;
            alu_op      <= 3'b000;
            alu_operand <= 8'h00;
            halted      <= 1'b0;
            fault       <= 1'b0;
            fault_code  <= FC_NONE;
            wait_cnt    <= 2'd0;
            accepted    <= 1'b0;
        end else begin
            case (state)
                S_FETCH: wait_cnt <= WAIT_INIT;
                S_WAIT:  if (wait_cnt != 2'd0) wait_cnt <= wait_cnt - 2'd1;
                S_ISSUE: begin
                    if (ir_op == OP_HALT) begin
                        halted <= 1'b1;
                    end else if (ir_op == OP_PUSH || is_binop(ir_op)) begin
                        if (trap_full || trap_under) begin
                            fault      <= 1'b1;
                            fault_code <= trap_full ? FC_FULL : FC_UNDER;
                        end else begin
                            alu_valid   <= 1'b1;
                            alu_op      <= ir_op;
                            alu_operand <= ir_arg;
                            accepted    <= 1'b0;
                        end
                    end else begin
                        pc <= pc + AW'(1);
                    end
                end
                S_EXEC: begin
                    if (handshake) begin
                        alu_valid <= 1'b0;
                        accepted  <= 1'b1;
                    end
                    if (op_done) begin
                        // The stack has already changed even when the result overflowed.
                        depth <= (alu_op == OP_PUSH) ? depth + 4'd1 : depth - 4'd1;
                        if (alu_ovf) begin
                            fault      <= 1'b1;
                            fault_code <= FC_OVF;
                        end else begin
                            pc <= pc + AW'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_calc_sequencer.sv
// Bench for calc_sequencer: random and directed programs checked against an instruction-level interpreter.
module tb_calc_sequencer;

    localparam int AW = 4;
    localparam int N  = 16;

    logic          CLOCK_50 = 1'b0;
    logic          reset_n;
    logic          run;
    logic          step;
    logic [AW-1:0] rom_addr;
    logic [10:0]   rom_q;
    logic          alu_valid;
    logic [2:0]    alu_op;
    logic [7:0]    alu_operand;
    logic          alu_ready;
    logic          alu_done;
    logic          alu_ovf;
    logic [AW-1:0] pc;
    logic [3:0]    depth;
    logic          busy;
    logic          halted;
    logic          fault;
    logic [1:0]    fault_code;

    logic [10:0] rom [N];
    int          n_cmp = 0;
    int          n_bad = 0;
    logic        hold_rdy = 1'b0;
    int          ovf_at = -1;
    logic [10:0] got_q [$];
    logic [10:0] exp_q [$];
    int          exp_pc;
    int          exp_depth;
    logic        exp_halt;
    logic        exp_fault;
    logic [1:0]  exp_code;

    calc_sequencer dut (
        .CLOCK_50    (CLOCK_50),
        .reset_n     (reset_n),
        .run         (run),
        .step        (step),
        .rom_addr    (rom_addr),
        .rom_q       (rom_q),
        .alu_valid   (alu_valid),
        .alu_op      (alu_op),
        .alu_operand (alu_operand),
        .alu_ready   (alu_ready),
        .alu_done    (alu_done),
        .alu_ovf     (alu_ovf),
        .pc          (pc),
        .depth       (depth),
        .busy        (busy),
        .halted      (halted),
        .fault       (fault),
        .fault_code  (fault_code)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    always @(posedge CLOCK_50) rom_q <= rom[rom_addr];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Datapath stand-in: random ready, done 0..4 cycles after accept (0 = same cycle).
    initial begin : alu_model
        int   pend;
        logic pend_ovf;
        pend      = -1;
        pend_ovf  = 1'b0;
        alu_ready = 1'b0;
        alu_done  = 1'b0;
        alu_ovf   = 1'b0;
        forever begin
            @(negedge CLOCK_50);
            alu_done = 1'b0;
            alu_ovf  = 1'b0;
            if (pend == 0) begin
                alu_done = 1'b1;
                alu_ovf  = pend_ovf;
                pend     = -1;
            end else if (pend > 0) begin
                pend--;
            end
            alu_ready = !hold_rdy && ($urandom_range(0, 3) != 0);
            if (alu_valid && alu_ready && reset_n) begin
                pend_ovf = (got_q.size() == ovf_at);
                got_q.push_back({alu_op, alu_operand});
                if ($urandom_range(0, 2) == 0) begin
                    alu_done = 1'b1;
                    alu_ovf  = pend_ovf;
                end else begin
                    pend = $urandom_range(0, 3);
                end
            end
        end
    end

    // Instruction-level interpreter of the current ROM.
    task automatic model_run(input int ovf_sel);
        int          p;
        int          d;
        int          n_alu;
        logic [10:0] w;
        logic [2:0]  op;
        exp_q.delete();
        p = 0; d = 0; n_alu = 0;
        exp_halt = 1'b0; exp_fault = 1'b0; exp_code = 2'b00;
        for (int k = 0; k < 64; k++) begin
            w  = rom[p];
            op = w[10:8];
            if (op == 3'b111) begin
                exp_halt = 1'b1;
                break;
            end
            if (op == 3'b011 || op == 3'b100 || op == 3'b101 || op == 3'b010) begin
                if (op == 3'b011 && d == 10) begin
                    exp_fault = 1'b1; exp_code = 2'b01;
                    break;
                end
                if (op != 3'b011 && d < 2) begin
                    exp_fault = 1'b1; exp_code = 2'b10;
                    break;
                end
                exp_q.push_back(w);
                d = (op == 3'b011) ? d + 1 : d - 1;
                if (n_alu == ovf_sel) begin
                    exp_fault = 1'b1; exp_code = 2'b11;
                    break;
                end
                n_alu++;
            end
            p = (p + 1) % N;
        end
        exp_pc    = p;
        exp_depth = d;
    endtask

    task automatic fill_halt();
        for (int i = 0; i < N; i++) rom[i] = {3'b111, 8'h00};
    endtask

    task automatic do_reset();
        reset_n  = 1'b0;
        run      = 1'b0;
        step     = 1'b0;
        hold_rdy = 1'b0;
        ovf_at   = -1;
        repeat (3) @(negedge CLOCK_50);
        reset_n = 1'b1;
        @(negedge CLOCK_50);
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_pc"}, pc, 0);
        check({tag, "_addr"}, rom_addr, 0);
        check({tag, "_depth"}, depth, 0);
        check({tag, "_vld"}, alu_valid, 0);
        check({tag, "_op"}, alu_op, 0);
        check({tag, "_arg"}, alu_operand, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_halted"}, halted, 0);
        check({tag, "_fault"}, fault, 0);
        check({tag, "_code"}, fault_code, 0);
    endtask

    task automatic run_prog(input string tag, input int ovf_sel);
        int t;
        int base;
        model_run(ovf_sel);
        do_reset();
        base   = got_q.size();
        ovf_at = (ovf_sel < 0) ? -1 : base + ovf_sel;
        run    = 1'b1;
        t      = 0;
        while (!(halted || fault) && t < 3000) begin
            @(negedge CLOCK_50);
            t++;
        end
        check({tag, "_ends"}, 32'(t < 3000), 1);
        repeat (10) @(negedge CLOCK_50);
        run = 1'b0;
        check({tag, "_hs_n"}, got_q.size() - base, exp_q.size());
        for (int i = 0; i < exp_q.size() && base + i < got_q.size(); i++) begin
            check({tag, "_hs_op"}, got_q[base+i][10:8], exp_q[i][10:8]);
            if (exp_q[i][10:8] == 3'b011)
                check({tag, "_hs_arg"}, got_q[base+i][7:0], exp_q[i][7:0]);
        end
        check({tag, "_pc"}, pc, exp_pc);
        check({tag, "_depth"}, depth, exp_depth);
        check({tag, "_halted"}, halted, exp_halt);
        check({tag, "_fault"}, fault, exp_fault);
        check({tag, "_code"}, fault_code, exp_code);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_vld"}, alu_valid, 0);
    endtask

    initial begin
        int          t;
        int          sel;
        logic [2:0]  nops [3];
        reset_n = 1'b0;
        run     = 1'b0;
        step    = 1'b0;
        nops[0] = 3'b000; nops[1] = 3'b001; nops[2] = 3'b110;
        fill_halt();
        repeat (2) @(negedge CLOCK_50);
        check_reset("rst");

        fill_halt();
        rom[0] = {3'b011, 8'd5}; rom[1] = {3'b011, 8'd3}; rom[2] = {3'b101, 8'd0};
        run_prog("push_sub", -1);
        check("push_sub_halted", halted, 1);
        check("push_sub_pc3", pc, 3);
        check("push_sub_depth1", depth, 1);

        fill_halt();
        rom[0] = {3'b011, 8'd100}; rom[1] = {3'b011, 8'd100}; rom[2] = {3'b100, 8'd0};
        run_prog("ovf", 2);
        check("ovf_code", fault_code, 2'b11);

        fill_halt();
        for (int i = 0; i < 11; i++) rom[i] = {3'b011, 8'(i + 1)};
        run_prog("full", -1);
        check("full_code", fault_code, 2'b01);
        check("full_depth", depth, 10);

        fill_halt();
        rom[0] = {3'b011, 8'd7}; rom[1] = {3'b010, 8'd0};
        run_prog("under", -1);
        check("under_code", fault_code, 2'b10);
        check("under_pc", pc, 1);

        for (int r = 0; r < 25; r++) begin
            for (int i = 0; i < N - 1; i++) begin
                sel = $urandom_range(0, 9);
                case (sel)
                    4:       rom[i] = {3'b100, 8'($urandom_range(0, 255))};
                    5:       rom[i] = {3'b101, 8'($urandom_range(0, 255))};
                    6:       rom[i] = {3'b010, 8'($urandom_range(0, 255))};
                    7:       rom[i] = {nops[$urandom_range(0, 2)], 8'($urandom_range(0, 255))};
                    8:       rom[i] = ($urandom_range(0, 3) == 0) ? {3'b111, 8'h00} : {3'b000, 8'h00};
                    default: rom[i] = {3'b011, 8'($urandom_range(0, 255))};
                endcase
            end
            rom[N-1] = {3'b111, 8'h00};
            run_prog("rnd", ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 4)) : -1);
        end

        fill_halt();
        rom[0] = {3'b000, 8'h11}; rom[1] = {3'b001, 8'h22}; rom[2] = {3'b110, 8'h33};
        do_reset();
        for (int i = 0; i < 5; i++) begin
            @(negedge CLOCK_50); step = 1'b1;
            @(negedge CLOCK_50); step = 1'b0;
            t = 0;
            while (!busy && t < 20) begin @(negedge CLOCK_50); t++; end
            if (i < 4) check("step_busy_seen", 32'(t < 20), 1);
            t = 0;
            while (busy && t < 20) begin @(negedge CLOCK_50); t++; end
            repeat (4) @(negedge CLOCK_50);
            check("step_pc", pc, (i < 3) ? i + 1 : 3);
            check("step_busy_low", busy, 0);
            check("step_halted", halted, (i >= 3) ? 1 : 0);
        end

        fill_halt();
        rom[0] = {3'b011, 8'h5A};
        do_reset();
        hold_rdy = 1'b1;
        run      = 1'b1;
        t = 0;
        while (!alu_valid && t < 100) begin @(negedge CLOCK_50); t++; end
        check("stall_vld_seen", 32'(t < 100), 1);
        repeat (5) begin
            @(negedge CLOCK_50);
            check("stall_vld", alu_valid, 1);
            check("stall_op", alu_op, 3'b011);
            check("stall_arg", alu_operand, 8'h5A);
        end
        @(posedge CLOCK_50);
        #3 reset_n = 1'b0;
        #1 check_reset("async_rst");
        hold_rdy = 1'b0;
        run      = 1'b0;
        @(negedge CLOCK_50);
        reset_n = 1'b1;
        repeat (3) @(negedge CLOCK_50);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
